// File: rtl/bin2bcd_seq_pkg.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq_pkg
// Shared project constants for the multiplier blocks and the sequential
// binary-to-BCD converter: FSM state encodings, the default BCD digit count
// and the magnitude helper used when a product is accepted.
// -----------------------------------------------------------------------------
package bin2bcd_seq_pkg;

    // Number of BCD digits produced by default.
    localparam int NDIG_DEFAULT = 4;

    // Converter FSM states; the fourth encoding is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } bcd_state_e;

    // Unsigned magnitude of a two's-complement value at its own width.
    // The most negative value maps onto 2^(W-1), which is representable
    // unsigned, so no extra bit is needed.
    function automatic logic [11:0] abs_mag12(input logic [11:0] value, input int width);
        logic [11:0] v_mask;
        logic [11:0] v_neg;
        v_mask = (12'd1 << width) - 12'd1;
        v_neg  = ((~value) + 12'd1) & v_mask;
        if (value[width-1]) begin
            abs_mag12 = v_neg;
        end else begin
            abs_mag12 = value & v_mask;
        end
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq_if
// Request/result bundle between the multiplier datapath and bin2bcd_seq.
//   start   : 1-cycle conversion request
//   product : two's-complement product, valid while start=1
//   busy    : conversion in progress
//   done    : 1-cycle pulse marking a new result
//   sign    : result is negative
//   bcd     : BCD magnitude, digit 0 in bits [3:0]
// master = requester (multiplier side), slave = converter.
// -----------------------------------------------------------------------------
interface bin2bcd_seq_if #(
    parameter int PROD_W = 10,
    parameter int NDIG   = 4
);
    logic                start;
    logic [PROD_W-1:0]   product;
    logic                busy;
    logic                done;
    logic                sign;
    logic [4*NDIG-1:0]   bcd;

    modport master (
        output start,
        output product,
        input  busy,
        input  done,
        input  sign,
        input  bcd
    );

    modport slave (
        input  start,
        input  product,
        output busy,
        output done,
        output sign,
        output bcd
    );
endinterface

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble correction for one BCD digit: a digit of 5 or
// more gets 3 added so that the following left shift carries correctly into
// the next digit.
//   i_digit : scratch digit before the shift
//   o_digit : corrected digit
// -----------------------------------------------------------------------------
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Add-3 correction for digits 5..9 (larger values never occur in scratch).
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end else begin
            o_digit = i_digit;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential shift-and-add-3 converter turning a signed multiplier product
// into sign + BCD magnitude. One shift per clock: a conversion takes
// PROD_W+2 edges from accepted start to the done pulse.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, dominates start
//   bus  : bin2bcd_seq_if slave (start/product in, busy/done/sign/bcd out)
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH_MUL = 5,
    parameter int PROD_W    = 2 * WIDTH_MUL,
    parameter int NDIG      = NDIG_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(PROD_W + 1);
    localparam int BCD_W = 4 * NDIG;

    bcd_state_e          r_state;
    bcd_state_e          w_state_next;

    logic [BCD_W-1:0]    r_scratch;
    logic [BCD_W-1:0]    w_scratch_next;
    logic [PROD_W-1:0]   r_shift;
    logic [PROD_W-1:0]   w_shift_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                r_sign_lat;
    logic                w_sign_lat_next;

    logic [BCD_W-1:0]    r_bcd;
    logic [BCD_W-1:0]    w_bcd_next;
    logic                r_sign;
    logic                w_sign_next;
    logic                r_done;
    logic                w_done_next;
    logic                r_busy;

    logic [BCD_W-1:0]    w_adj;
    logic [11:0]         w_mag12;

    // Per-digit add-3 correction of the scratch before each shift.
    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_scratch[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    // Magnitude of the incoming product at PROD_W bits.
    assign w_mag12 = abs_mag12(12'(bus.product), PROD_W);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        w_state_next    = r_state;
        w_scratch_next  = r_scratch;
        w_shift_next    = r_shift;
        w_cnt_next      = r_cnt;
        w_sign_lat_next = r_sign_lat;
        w_bcd_next      = r_bcd;
        w_sign_next     = r_sign;
        w_done_next     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_sign_lat_next = bus.product[PROD_W-1];
                    w_shift_next    = w_mag12[PROD_W-1:0];
                    w_scratch_next  = '0;
                    w_cnt_next      = '0;
                    w_state_next    = CONV;
                end else begin
                    w_state_next    = IDLE;
                end
            end
            CONV: begin
                // Adjusted scratch and shift register move left as one word.
                w_scratch_next = {w_adj[BCD_W-2:0], r_shift[PROD_W-1]};
                w_shift_next   = {r_shift[PROD_W-2:0], 1'b0};
                w_cnt_next     = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                if (r_cnt == CNT_W'(PROD_W - 1)) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = CONV;
                end
            end
            DONE: begin
                w_bcd_next   = r_scratch;
                w_sign_next  = r_sign_lat;
                w_done_next  = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scratch  <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_sign_lat <= 1'b0;
            r_bcd      <= '0;
            r_sign     <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_scratch  <= w_scratch_next;
            r_shift    <= w_shift_next;
            r_cnt      <= w_cnt_next;
            r_sign_lat <= w_sign_lat_next;
            r_bcd      <= w_bcd_next;
            r_sign     <= w_sign_next;
            r_done     <= w_done_next;
            r_busy     <= (w_state_next != IDLE);
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sign = r_sign;
    assign bus.bcd  = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
// Directed bench for bin2bcd_seq at WIDTH_MUL=5 (PROD_W=10, NDIG=4).
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    bin2bcd_seq_if #(.PROD_W(10), .NDIG(4)) bus ();

    bin2bcd_seq #(.WIDTH_MUL(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  product;
        logic        exp_sign;
        logic [15:0] exp_bcd;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full conversion: start at edge 0, done expected after edge 11 only.
    task automatic do_conv(input logic [9:0] p, input logic es, input logic [15:0] eb);
        logic early;
        bus.product = p;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        early = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (bus.done) early = 1'b1;
        end
        check("no_early_done", 32'(early), 32'd0);
        tick();
        check("done_at_11", 32'(bus.done), 32'd1);
        check("sign", 32'(bus.sign), 32'(es));
        check("bcd", 32'(bus.bcd), 32'(eb));
        tick();
        check("done_cleared", 32'(bus.done), 32'd0);
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("bcd_hold", 32'(bus.bcd), 32'(eb));
    endtask

    initial begin
        logic seen;
        n_cmp = 0;
        n_err = 0;
        vecs[0] = '{10'd255, 1'b0, 16'h0255};
        vecs[1] = '{10'h310, 1'b1, 16'h0240};
        vecs[2] = '{10'h200, 1'b1, 16'h0512};
        vecs[3] = '{10'd0,   1'b0, 16'h0000};
        vecs[4] = '{10'd7,   1'b0, 16'h0007};
        vecs[5] = '{10'd511, 1'b0, 16'h0511};
        vecs[6] = '{10'h3FF, 1'b1, 16'h0001};
        vecs[7] = '{10'd99,  1'b0, 16'h0099};

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.product = 10'd0;
        tick();
        tick();
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_sign", 32'(bus.sign), 32'd0);
        check("reset_bcd",  32'(bus.bcd),  32'd0);

        // rst dominates a simultaneous start.
        bus.start   = 1'b1;
        bus.product = 10'd255;
        tick();
        check("rst_over_start", 32'(bus.busy), 32'd0);
        bus.start = 1'b0;
        rst       = 1'b0;
        tick();

        for (int v = 0; v < 8; v++) begin
            do_conv(vecs[v].product, vecs[v].exp_sign, vecs[v].exp_bcd);
        end

        // Start at edge 4 while busy must be ignored.
        bus.product = 10'd255;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 4) begin
                bus.product = 10'd99;
                bus.start   = 1'b1;
            end
            tick();
            bus.start = 1'b0;
            if (bus.done) seen = 1'b1;
        end
        check("ignore_no_early_done", 32'(seen), 32'd0);
        tick();
        check("ignore_done", 32'(bus.done), 32'd1);
        check("ignore_bcd", 32'(bus.bcd), 32'h0255);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        check("ignore_no_second_done", 32'(seen), 32'd0);

        // Back-to-back: start 7 in the done cycle.
        bus.product = 10'h310;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 10; i++) tick();
        tick();
        check("b2b_first_done", 32'(bus.done), 32'd1);
        check("b2b_first_bcd", 32'(bus.bcd), 32'h0240);
        bus.product = 10'd7;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        seen = 1'b0;
        for (int i = 13; i <= 22; i++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        check("b2b_no_early_done", 32'(seen), 32'd0);
        check("b2b_hold_sign", 32'(bus.sign), 32'd1);
        check("b2b_hold_bcd", 32'(bus.bcd), 32'h0240);
        tick();
        check("b2b_second_done", 32'(bus.done), 32'd1);
        check("b2b_second_bcd", 32'(bus.bcd), 32'h0007);
        check("b2b_second_sign", 32'(bus.sign), 32'd0);
        tick();

        // rst at edge 5 aborts the conversion.
        bus.product = 10'd255;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_bcd", 32'(bus.bcd), 32'd0);
        check("abort_sign", 32'(bus.sign), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        check("abort_bcd_still_zero", 32'(bus.bcd), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter: WIDTH_MUL, default 5, multiplier operand width in bits; legal range 2..6.
REQ-002 Parameter: PROD_W, default 2*WIDTH_MUL, signed product width in bits; always derived, never overridden.
REQ-003 Parameter: NDIG, default 4, number of BCD digits produced.
REQ-004 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  reset; synchronous, active-high.
REQ-006 Port: start  input  1  conversion request; a 1-cycle pulse driven by the multiplier FSM en_bcd output.
REQ-007 Port: product  input  PROD_W  two's-complement product from the multiplier datapath; valid in the cycle start=1.
REQ-008 Port: busy  output  1  high while a conversion is in progress.
REQ-009 Port: done  output  1  registered 1-cycle pulse marking new results.
REQ-010 Port: sign  output  1  1 = product was negative.
REQ-011 Port: bcd  output  4*NDIG  magnitude as BCD; digit 0 (units) in bits [3:0].

Function
REQ-012 FSM states SHALL be IDLE, CONV and DONE, and the FSM SHALL leave every unused encoding for IDLE on the next edge.
REQ-013 IDLE, start=1 at edge k: the block SHALL latch sign=product[PROD_W-1] internally, load |product| into the shift register, clear the BCD scratch and bit counter, and go to CONV.
REQ-014 Magnitude SHALL be computed at PROD_W bits unsigned; -2^(PROD_W-1) SHALL yield 2^(PROD_W-1) without overflow.
REQ-015 CONV, each edge: every scratch digit >=5 SHALL be increased by 3, then {scratch, shift register} SHALL shift left by 1 and the counter SHALL increment.
REQ-016 CONV SHALL perform exactly PROD_W shifts (edges k+1..k+PROD_W), and the edge of the last shift SHALL move the FSM to DONE.
REQ-017 DONE, edge k+PROD_W+1: the block SHALL load the scratch into bcd, load the latched sign into sign, set done=1 and go to IDLE.
REQ-018 done SHALL clear on the following edge, so that it is high for exactly one cycle.
REQ-019 busy SHALL be 1 in CONV and DONE and 0 in IDLE.
REQ-020 The block SHALL ignore start while busy=1, with no restart and no queuing.
REQ-021 The block SHALL accept start in the cycle done=1, because the FSM is then in IDLE, giving back-to-back conversions.
REQ-022 bcd and sign SHALL hold their last result until the next DONE edge.
REQ-023 Every digit of bcd SHALL be in 0..9.
REQ-024 A product of zero SHALL yield sign=0 and bcd=0.

Reset
REQ-025 When rst=1 at an edge, the block SHALL go to IDLE and clear busy, done, sign, bcd, the scratch, the shift register and the counter to 0.
REQ-026 rst SHALL take priority over start.
REQ-027 rst during CONV or DONE SHALL abort the conversion with no done pulse, and the interrupted result SHALL never appear on bcd.

Structure
REQ-028 The state encodings (IDLE/CONV/DONE) and the NDIG default SHALL live in the shared project constants package/header used by the multiplier blocks.
REQ-029 The per-digit "add 3 if >=5" step SHALL be a combinational sub-module, bcd_digit_adj, instantiated NDIG times.
REQ-030 The top level SHALL contain the FSM, counter and registers only.

Verification (WIDTH_MUL=5, PROD_W=10, start at edge 0)
REQ-031 product=10'd255 -> busy=1 after edge 0; done=1 after edge 11 only; sign=0, bcd=16'h0255.
REQ-032 product=-240 (10'h310) -> sign=1, bcd=16'h0240; then product=-512 (10'h200) -> sign=1, bcd=16'h0512.
REQ-033 product=0 -> sign=0, bcd=16'h0000, done after edge 11.
REQ-034 start again at edge 4 with product=10'd99 -> ignored; result is still 16'h0255 at edge 11.
REQ-035 rst=1 at edge 5 -> busy=0, bcd=0, sign=0 after edge 5; no done pulse in the next 15 cycles.
REQ-036 start with 10'd7 in the done cycle (edge 11) -> second done after edge 23; bcd=16'h0007 and sign=0.
